param_serial_adder: RTL and testbench

Parametrised digit-serial adder: the sequential successor to the combinational parametrised half adder. It adds two WIDTH-bit operands and a carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle. A start/busy/done handshake lets a controller or bench trade latency for a narrow adder datapath. It sits behind any block that needs a cheap wide add and can tolerate multi-cycle latency.

---
 rtl/param_serial_adder.sv | 154 +++++++++++++++
 tb/tb_param_serial_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
// Optional signed-overflow flag is built when PARAM_SERIAL_ADDER_OVF_EN is defined.
module param_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned K  = WIDTH / DIGIT;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned DW = DIGIT + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   digit_res;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;

`ifdef PARAM_SERIAL_ADDER_OVF_EN
  logic [1:0]       sign_q, sign_d;
  logic             ovf_q, ovf_d;
`endif

  // One digit of the add; the result enters the accumulator from the MSB side.
  assign digit_res  = DW'(a_q[DIGIT-1:0]) + DW'(b_q[DIGIT-1:0]) + DW'(carry_q);
  assign acc_next   = WIDTH'({digit_res[DIGIT-1:0], acc_q} >> DIGIT);
  assign last_digit = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef PARAM_SERIAL_ADDER_OVF_EN
    sign_d  = sign_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef PARAM_SERIAL_ADDER_OVF_EN
          sign_d  = {a_i[WIDTH-1], b_i[WIDTH-1]};
`endif
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = digit_res[DIGIT];
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sum_d   = acc_next;
          cout_d  = digit_res[DIGIT];
`ifdef PARAM_SERIAL_ADDER_OVF_EN
          ovf_d   = (sign_q[1] == sign_q[0]) && (acc_next[WIDTH-1] != sign_q[1]);
`endif
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef PARAM_SERIAL_ADDER_OVF_EN
      sign_q  <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef PARAM_SERIAL_ADDER_OVF_EN
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef PARAM_SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`else
  assign ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_param_serial_adder.sv
// Bench for param_serial_adder: three configurations (8x1, 8x4, 4x2) checked every cycle
// against a timing/arithmetic reference model, plus directed literal expectations.
module tb_param_serial_adder;

  localparam int NI = 3;
  localparam int WS [NI] = '{8, 8, 4};
  localparam int KS [NI] = '{8, 2, 2};
`ifdef PARAM_SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] st;
  logic [NI-1:0] cv;
  logic [7:0]    av [NI];
  logic [7:0]    bv [NI];

  logic [NI-1:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0]    sum0, sum1;
  logic [3:0]    sum2;
  logic [7:0]    sum_w [NI];

  always_comb begin
    sum_w[0] = sum0;
    sum_w[1] = sum1;
    sum_w[2] = {4'h0, sum2};
  end

  param_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start_i(st[0]), .a_i(av[0]), .b_i(bv[0]), .cin_i(cv[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .sum_o(sum0), .cout_o(cout_w[0]), .ovf_o(ovf_w[0]));

  param_serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start_i(st[1]), .a_i(av[1]), .b_i(bv[1]), .cin_i(cv[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .sum_o(sum1), .cout_o(cout_w[1]), .ovf_o(ovf_w[1]));

  param_serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst(rst), .start_i(st[2]), .a_i(av[2][3:0]), .b_i(bv[2][3:0]), .cin_i(cv[2]),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .sum_o(sum2), .cout_o(cout_w[2]), .ovf_o(ovf_w[2]));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cycle %0d: got %h, want %h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: an operation accepted at edge E0 completes at edge E0+K,
  // its result is plain integer arithmetic, and the unit is idle again from E0+K+1.
  int            m_e0 [NI];
  bit            m_idle;
  logic [7:0]    p_sum [NI];
  logic [NI-1:0] p_cout, p_ovf;
  logic [NI-1:0] ex_busy, ex_done, ex_cout, ex_ovf;
  logic [7:0]    ex_sum [NI];

  task automatic predict(input int i);
    int w    = WS[i];
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int ua   = int'(av[i]) & mask;
    int ub   = int'(bv[i]) & mask;
    int uc   = int'(cv[i]);
    int tot  = ua + ub + uc;
    int sa   = (ua >= half) ? ua - (1 << w) : ua;
    int sb   = (ub >= half) ? ub - (1 << w) : ub;
    int ss   = sa + sb + uc;
    p_sum[i]  = 8'(tot & mask);
    p_cout[i] = ((tot >> w) & 1) != 0;
    p_ovf[i]  = OVF_ON && ((ss >= half) || (ss < -half));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_e0[i]    = -1;
        ex_busy[i] = 1'b0;
        ex_done[i] = 1'b0;
        ex_sum[i]  = 8'h00;
        ex_cout[i] = 1'b0;
        ex_ovf[i]  = 1'b0;
      end else begin
        m_idle     = (m_e0[i] < 0);
        ex_done[i] = 1'b0;
        if (!m_idle && cyc == m_e0[i] + KS[i]) begin
          ex_done[i] = 1'b1;
          ex_sum[i]  = p_sum[i];
          ex_cout[i] = p_cout[i];
          ex_ovf[i]  = p_ovf[i];
        end
        if (!m_idle && cyc == m_e0[i] + KS[i] + 1) m_e0[i] = -1;
        if (m_idle && st[i]) begin
          m_e0[i] = cyc;
          predict(i);
        end
        ex_busy[i] = (m_e0[i] >= 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("busy", i, 32'(busy_w[i]), 32'(ex_busy[i]));
        check("done", i, 32'(done_w[i]), 32'(ex_done[i]));
        check("sum",  i, 32'(sum_w[i]),  32'(ex_sum[i]));
        check("cout", i, 32'(cout_w[i]), 32'(ex_cout[i]));
        check("ovf",  i, 32'(ovf_w[i]),  32'(ex_ovf[i]));
      end
    end
  end

  task automatic go(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                    output int e0);
    st[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
    cv[i] = c;
    @(negedge clk);
    st[i] = 1'b0;
    e0 = cyc;
  endtask

  task automatic run(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo, input int elat);
    int e0, lat, bcnt;
    go(i, a, b, c, e0);
    lat = -1;
    bcnt = 0;
    for (int t = 0; t < 64; t++) begin
      if (busy_w[i]) bcnt++;
      if (done_w[i]) begin
        lat = cyc - e0;
        break;
      end
      @(negedge clk);
    end
    check("latency",     i, 32'(lat),  32'(elat));
    check("busy_cycles", i, 32'(bcnt), 32'(elat + 1));
    check("lit_sum",     i, 32'(sum_w[i]),  32'(es));
    check("lit_cout",    i, 32'(cout_w[i]), 32'(ec));
    check("lit_ovf",     i, 32'(ovf_w[i]),  32'(eo));
    @(negedge clk);
  endtask

  initial begin
    int e0, nd;
    int dcyc [2];
    logic [7:0] dsum [2];
    logic dcout [2];

    st = '0;
    cv = '0;
    for (int i = 0; i < NI; i++) begin
      av[i] = 8'h00;
      bv[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_sum",  0, 32'(sum_w[0]),  32'h0);
    check("rst_busy", 0, 32'(busy_w[0]), 32'h0);
    check("rst_done", 0, 32'(done_w[0]), 32'h0);

    run(0, 8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 8);
    run(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
    run(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 2);
    run(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
    run(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 2);
    run(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON, 8);
    run(0, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, OVF_ON, 8);
    run(2, 8'h09, 8'h08, 1'b0, 8'h01, 1'b1, OVF_ON, 2);

    // Starts during RUN and during the DONE cycle must be dropped.
    go(0, 8'h10, 8'h20, 1'b0, e0);
    nd = 0;
    for (int t = 0; t < 30; t++) begin
      if (cyc == e0 + 1 || cyc == e0 + KS[0]) begin
        st[0] = 1'b1;
        av[0] = 8'hAA;
        bv[0] = 8'h55;
      end else begin
        st[0] = 1'b0;
      end
      if (done_w[0]) nd++;
      @(negedge clk);
    end
    check("reject_dones", 0, 32'(nd), 32'd1);
    check("reject_sum",   0, 32'(sum_w[0]), 32'h30);

    // Reset four cycles into an operation.
    go(0, 8'h12, 8'h34, 1'b0, e0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 0, 32'(busy_w[0]), 32'h0);
    check("midrst_sum",  0, 32'(sum_w[0]),  32'h0);
    nd = 0;
    for (int t = 0; t < 15; t++) begin
      if (done_w[0]) nd++;
      @(negedge clk);
    end
    check("midrst_dones", 0, 32'(nd), 32'd0);
    run(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 8);

    // Start held high on the 4x2 unit: completions every K+2 cycles.
    st[2] = 1'b1;
    av[2] = 8'h09;
    bv[2] = 8'h08;
    cv[2] = 1'b0;
    @(negedge clk);
    e0 = cyc;
    av[2] = 8'h01;
    bv[2] = 8'h01;
    nd = 0;
    dcyc[0] = 0;
    dcyc[1] = 0;
    for (int t = 0; t < 16; t++) begin
      if (cyc == e0 + 4) st[2] = 1'b0;
      if (done_w[2] && nd < 2) begin
        dcyc[nd]  = cyc;
        dsum[nd]  = sum_w[2];
        dcout[nd] = cout_w[2];
        nd++;
      end
      @(negedge clk);
    end
    st[2] = 1'b0;
    check("b2b_dones", 2, 32'(nd), 32'd2);
    if (nd == 2) begin
      check("b2b_first_lat", 2, 32'(dcyc[0] - e0),      32'd2);
      check("b2b_period",    2, 32'(dcyc[1] - dcyc[0]), 32'd4);
      check("b2b_sum0",      2, 32'(dsum[0]),  32'h1);
      check("b2b_cout0",     2, 32'(dcout[0]), 32'h1);
      check("b2b_sum1",      2, 32'(dsum[1]),  32'h2);
      check("b2b_cout1",     2, 32'(dcout[1]), 32'h0);
    end

    // Random traffic on all three units, including occasional resets.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NI; i++) begin
        st[i] = ($urandom_range(0, 2) == 0);
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        cv[i] = 1'($urandom);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    st = '0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
